// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory arbiter and its helpers.
//   - MemOp encodings as seen on the memory port
//   - arbiter FSM states
//   - request owner IDs
package mem_arb_pkg;

    localparam logic [2:0] MemOpB  = 3'b000;  // byte, sign-extended
    localparam logic [2:0] MemOpH  = 3'b001;  // half, sign-extended
    localparam logic [2:0] MemOpW  = 3'b010;  // word
    localparam logic [2:0] MemOpBu = 3'b100;  // byte, zero-extended
    localparam logic [2:0] MemOpHu = 3'b101;  // half, zero-extended

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the IFU, LSU and memory-side signals of mem_arbiter.
//   slave  : arbiter view (takes requests and mem_rdata, drives responses and strobes)
//   master : environment view (IFU, LSU and memory model)
interface mem_arbiter_if;
    // IFU request / response
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    // LSU request / response
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [2:0]  lsu_memop;
    logic [31:0] lsu_wdata;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_rdata;
    logic        lsu_resp_err;
    // Memory port
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  mem_memop;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  ifu_req_valid, ifu_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata, lsu_resp_ready,
        input  mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        output mem_addr, mem_rd, mem_wr, mem_memop, mem_wdata
    );

    modport master (
        output ifu_req_valid, ifu_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_addr, lsu_wen, lsu_memop, lsu_wdata, lsu_resp_ready,
        output mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
        input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
        input  mem_addr, mem_rd, mem_wr, mem_memop, mem_wdata
    );

endinterface

// File: rtl/mem_align_chk.sv
// mem_align_chk: combinational access legality check.
//   addr_lo_i : address bits [1:0]
//   memop_i   : MemOp encoding
//   wen_i     : 1 = store
//   err_o     : access is misaligned or the MemOp is illegal for this direction
module mem_align_chk
    import mem_arb_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [2:0] memop_i,
    input  logic       wen_i,
    output logic       err_o
);

    always_comb begin
        err_o = 1'b0;
        case (memop_i)
            MemOpB:  err_o = 1'b0;
            MemOpBu: err_o = wen_i;
            MemOpH:  err_o = (addr_lo_i == 2'b11);
            // Halves may straddle bytes 1..2 but never a word boundary
            MemOpHu: err_o = wen_i || (addr_lo_i == 2'b11);
            MemOpW:  err_o = (addr_lo_i != 2'b00);
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IFU (word reads) and LSU (loads/stores).
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_arbiter_if.slave carrying IFU/LSU request and response channels
//              and the memory port (addr, rd/wr strobes, memop, wdata, rdata)
//   LATENCY  : extra wait cycles between the memory access and the response (0..15)
// One transaction in flight; ties are broken round-robin at the IDLE decision.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int unsigned CntW = (LATENCY == 0) ? 1 : $clog2(LATENCY + 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_grant_q, last_grant_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [2:0]    memop_q, memop_d;
    logic          wen_q, wen_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic          req_err;
    logic          grant_ifu;
    logic          ifu_ready, lsu_ready;

    mem_align_chk u_align_chk (
        .addr_lo_i (addr_q[1:0]),
        .memop_i   (memop_q),
        .wen_i     (wen_q),
        .err_o     (req_err)
    );

    // IFU wins unless the LSU also asks and the IFU was served last
    assign grant_ifu = bus.ifu_req_valid && (!bus.lsu_req_valid || (last_grant_q == OWN_LSU));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        memop_d      = memop_q;
        wen_d        = wen_q;
        cnt_d        = cnt_q;
        ifu_ready    = 1'b0;
        lsu_ready    = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.mem_wr   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_ifu) begin
                    ifu_ready    = 1'b1;
                    owner_d      = OWN_IFU;
                    last_grant_d = OWN_IFU;
                    addr_d       = bus.ifu_addr;
                    wen_d        = 1'b0;
                    memop_d      = MemOpW;
                    wdata_d      = '0;
                    state_d      = StAccess;
                end else if (bus.lsu_req_valid) begin
                    lsu_ready    = 1'b1;
                    owner_d      = OWN_LSU;
                    last_grant_d = OWN_LSU;
                    addr_d       = bus.lsu_addr;
                    wen_d        = bus.lsu_wen;
                    memop_d      = bus.lsu_memop;
                    wdata_d      = bus.lsu_wdata;
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                bus.mem_rd = !req_err && !wen_q;
                bus.mem_wr = !req_err && wen_q;
                rdata_d    = (!req_err && !wen_q) ? bus.mem_rdata : '0;
                if (LATENCY == 0) begin
                    state_d = StResp;
                end else begin
                    state_d = StWait;
                    cnt_d   = CntW'(LATENCY);
                end
            end
            StWait: begin
                if (cnt_q == CntW'(1)) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StResp: begin
                if ((owner_q == OWN_IFU) ? bus.ifu_resp_ready : bus.lsu_resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is combinational from inputs, so mask it while reset is held
    assign bus.ifu_req_ready  = ifu_ready && !rst;
    assign bus.lsu_req_ready  = lsu_ready && !rst;

    assign bus.ifu_resp_valid = (state_q == StResp) && (owner_q == OWN_IFU);
    assign bus.lsu_resp_valid = (state_q == StResp) && (owner_q == OWN_LSU);
    assign bus.ifu_resp_err   = bus.ifu_resp_valid && req_err;
    assign bus.lsu_resp_err   = bus.lsu_resp_valid && req_err;
    assign bus.ifu_rdata      = rdata_q;
    assign bus.lsu_rdata      = rdata_q;

    assign bus.mem_addr       = addr_q;
    assign bus.mem_memop      = memop_q;
    assign bus.mem_wdata      = wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_LSU;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            memop_q      <= '0;
            wen_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            memop_q      <= memop_d;
            wen_q        <= wen_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer that shares the single data memory port (addr/MemRd/MemWr/MemOp/in/out) between instruction fetch (IFU, word reads only) and load/store (LSU, all MemOp widths, read or write). It accepts one request at a time with valid/ready handshakes and grants round-robin when both request. It drives the memory strobes for exactly one cycle and models a configurable access latency. It returns read data or completion on a per-requester response channel. It sits between IFU/LSU and the memory block in the npc core.

## Interface
- LATENCY, 2, extra wait cycles between memory access and response; legal 0..15
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  in  1  IFU request present
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  32  IFU word address
- ifu_resp_valid  out  1  IFU response available
- ifu_resp_ready  in  1  IFU takes response
- ifu_rdata  out  32  fetched word
- ifu_resp_err  out  1  IFU address misaligned
- lsu_req_valid  in  1  LSU request present
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  32  byte address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_memop  in  3  MemOp encoding (000 b/sext, 001 h/sext, 010 w, 100 bu, 101 hu)
- lsu_wdata  in  32  store data
- lsu_resp_valid  out  1  LSU response available
- lsu_resp_ready  in  1  LSU takes response
- lsu_rdata  out  32  load result (0 for stores)
- lsu_resp_err  out  1  misaligned address or illegal MemOp
- mem_addr  out  32  memory byte address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mem_memop  out  3  MemOp to memory
- mem_wdata  out  32  write data to memory
- mem_rdata  in  32  memory read result, valid in the same cycle as mem_rd

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: if any req_valid, grant one: only one valid -> that one; both -> the one not granted last (last_grant). Granted req_ready=1 combinationally; the other ready=0. Latch addr/wen/memop/wdata and owner; update last_grant; go to ACCESS. req_ready is 0 in all other states.
- IFU request is internally memop=010, wen=0.
- Alignment check on latched request: err if memop∈{001,101} and addr[1:0]=11; if memop=010 and addr[1:0]≠00; if memop∉{000,001,010,100,101}; if store with memop∈{100,101}.
- ACCESS (one cycle): if no err, mem_rd=!wen or mem_wr=wen, mem_addr/mem_memop/mem_wdata from latches; capture mem_rdata (loads) into rdata register, 0 for stores. If err, no strobe, rdata=0. Go to WAIT if LATENCY>0, else RESP.
- WAIT: down-counter loaded with LATENCY, RESP when it reaches 1 cycle count exhausted (exactly LATENCY cycles in WAIT).
- RESP: owner's resp_valid=1, rdata and resp_err stable until resp_ready; on resp_valid&resp_ready go to IDLE. Non-owner resp_valid=0.
- Outside ACCESS, mem_rd=mem_wr=0; mem_addr/mem_memop/mem_wdata hold latched values.

## Timing
- Reset (async, any state): state=IDLE, all req_ready/resp_valid/resp_err/mem_rd/mem_wr=0, rdata/mem_addr/mem_wdata=0, mem_memop=0, last_grant=LSU (IFU wins first tie). In-flight request dropped, no response.
- Accept at cycle T -> ACCESS T+1 -> WAIT T+2..T+1+LATENCY -> resp_valid first at T+2+LATENCY.
- resp_ready at first RESP cycle -> IDLE next cycle; next accept earliest that cycle. Max throughput one transaction per LATENCY+3 cycles.
- Requester dropping req_valid before acceptance is legal; no accept occurs. Requests presented during a busy transaction wait; fairness resolved only at the IDLE decision.
- resp_ready asserted outside RESP is ignored.

## Structure
- Shared package/header mem_arb_pkg: MemOp encodings, state encodings, owner IDs (OWN_IFU=0, OWN_LSU=1).
- Sub-module mem_align_chk: combinational addr[1:0]/memop/wen -> err, reused by the LSU for trap detection.
- Counter width $clog2(LATENCY+1), min 1.

## Test plan
- Reset, IFU reads 0x8000_0000, mem_rdata=0x0000_0413, LATENCY=2 -> mem_rd one cycle at T+1, ifu_resp_valid at T+4, ifu_rdata=0x0000_0413, err=0.
- IFU and LSU valid together twice in succession -> IFU granted first, LSU second; LSU rdata correct; mem_rd never overlaps.
- LSU store memop=000 addr 0x8000_0003 wdata 0xAB -> mem_wr one cycle, mem_addr=0x8000_0003, mem_memop=000, lsu_resp_valid with rdata=0.
- LSU load memop=010 addr 0x8000_0002 -> no mem_rd/mem_wr, lsu_resp_err=1, rdata=0; memop=011 also err.
- Resp_ready held low 5 cycles -> resp_valid/rdata stable, no new accept, ifu_req_ready=0 throughout.
- rst pulsed during WAIT -> all outputs 0 immediately, no response afterwards, next request with LATENCY=0 responds at T+2.
